// File: rtl/multdiv_arbiter.sv
// Round-robin sharing of one iterative multiply/divide unit between two requesters.
// Define MULTDIV_ARB_TIMEOUT_EN to compile in the WAIT cycle counter and timeout abort path.
module multdiv_arbiter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        exception,
  output logic        timeout,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        op_q, op_d;
  logic        last_q, last_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        sel1;
  logic        rdy_ok;
  logic        expire;

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("multdiv_arbiter: TIMEOUT must be at least 2");
  end

`ifdef MULTDIV_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StStart) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // RDY seen in the first WAIT cycle may be left over from the previous op.
  assign rdy_ok = md_resultRDY && (cnt_q != '0);
  assign expire = !md_resultRDY && (cnt_q == CntLast);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == StWait && (rdy_ok || expire)) begin
        to_q <= !rdy_ok;
      end
    end
  end

  assign timeout = to_q;
`else
  logic first_q;

  assign rdy_ok = md_resultRDY && !first_q;
  assign expire = 1'b0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      first_q <= 1'b0;
    end else if (state_q == StStart) begin
      first_q <= 1'b1;
    end else if (state_q == StWait) begin
      first_q <= 1'b0;
    end
  end

  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    last_d       = last_q;
    result_d     = result_q;
    exc_d        = exc_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    // On a tie the port that was not served last wins.
    sel1         = req1 && (!req0 || !last_q);
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d = sel1;
          op_d    = sel1 ? op1 : op0;
          opa_d   = sel1 ? a1 : a0;
          opb_d   = sel1 ? b1 : b0;
          state_d = StStart;
        end
      end
      StStart: begin
        gnt0         = !owner_q;
        gnt1         = owner_q;
        md_ctrl_MULT = !op_q;
        md_ctrl_DIV  = op_q;
        state_d      = StWait;
      end
      StWait: begin
        if (rdy_ok) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = StDone;
        end else if (expire) begin
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        done0   = !owner_q;
        done1   = owner_q;
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      op_q     <= 1'b0;
      last_q   <= 1'b1;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      last_q   <= last_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign result      = result_q;
  assign exception   = exc_q;
  assign md_operandA = opa_q;
  assign md_operandB = opb_q;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Self-checking bench for multdiv_arbiter with a behavioural multiply/divide unit model.
// Covers the MULTDIV_ARB_TIMEOUT_EN build (TIMEOUT=8) and the default build.
module tb_multdiv_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] result;
  logic        exception, timeout;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;

  int checks = 0;
  int errors = 0;
  int ctrl_pulses = 0;

  // Multdiv model controls and state.
  int          mlat = 1;
  logic        mhang = 1'b0;
  int          mc = 0;
  logic        mactive = 1'b0;
  logic [32:0] mpend = '0;

  always #5 clock = ~clock;

  multdiv_arbiter #(.TIMEOUT(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req0         (req0),
    .req1         (req1),
    .op0          (op0),
    .op1          (op1),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .done0        (done0),
    .done1        (done1),
    .result       (result),
    .exception    (exception),
    .timeout      (timeout),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY)
  );

  // {exception, result} of a signed multiply (low word) or divide; divide by zero raises exception.
  function automatic logic [32:0] ref_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op) return {1'b0, a * b};
    if (b == 32'd0) return {1'b1, 32'd0};
    return {1'b0, 32'($signed(a) / $signed(b))};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multdiv stand-in: garbage with RDY high in the first cycle after start (stale), then
  // RDY low until the latency elapses; result and RDY then stay up until the next start.
  always @(negedge clock) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      ctrl_pulses++;
      mpend   = ref_op(md_ctrl_DIV, md_operandA, md_operandB);
      mc      = 0;
      mactive = 1'b1;
    end else if (mactive) begin
      mc++;
      if (mc == 1) begin
        md_resultRDY = 1'b1;
        md_result    = $urandom;
        md_exception = 1'($urandom_range(0, 1));
      end else if (!mhang && mc == mlat + 1) begin
        md_resultRDY = 1'b1;
        md_result    = mpend[31:0];
        md_exception = mpend[32];
        mactive      = 1'b0;
      end else begin
        md_resultRDY = 1'b0;
        md_result    = $urandom;
        md_exception = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("exclusive", {gnt0 & gnt1, done0 & done1, md_ctrl_MULT & md_ctrl_DIV}, 64'd0);
    end
  end

  // Waits for the grant, checks the start pulse and operands, then the done timing and result.
  task automatic serve(input int port, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int gnt_dly, input logic hang, input logic drop,
                       input logic [32:0] exp_er, input logic exp_to, input string tag);
    int n;
    int c0;
    mlat = lat;
    mhang = hang;
    c0 = ctrl_pulses;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(gnt0 || gnt1) && n < 20);
    chk({tag, "/gnt_dly"}, 64'(n), 64'(gnt_dly));
    chk({tag, "/gnt_port"}, {gnt1, gnt0}, (port == 1) ? 2'b10 : 2'b01);
    chk({tag, "/start"}, {md_ctrl_DIV, md_ctrl_MULT}, op ? 2'b10 : 2'b01);
    chk({tag, "/operands"}, {md_operandA, md_operandB}, {a, b});
    if (drop) begin
      if (port == 0) req0 = 1'b0;
      else req1 = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(done0 || done1) && n < 100);
    chk({tag, "/done_dly"}, 64'(n), 64'(lat + 2));
    chk({tag, "/done_port"}, {done1, done0}, (port == 1) ? 2'b10 : 2'b01);
    chk({tag, "/result"}, {exception, result}, exp_er);
    chk({tag, "/timeout"}, timeout, exp_to);
    chk({tag, "/pulses"}, 64'(ctrl_pulses - c0), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/ctl"}, {gnt0, gnt1, done0, done1, md_ctrl_MULT, md_ctrl_DIV, exception, timeout},
        64'd0);
    chk({tag, "/result"}, result, 64'd0);
    chk({tag, "/operands"}, {md_operandA, md_operandB}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int   tb_last;
    int   port;
    int   n;
    logic op;
    logic seen_done;
    logic [31:0] a, b;

    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Single multiply from idle.
    req0 = 1'b1; op0 = 1'b0; a0 = 32'd6; b0 = 32'd7;
    serve(0, 1'b0, 32'd6, 32'd7, 3, 1, 1'b0, 1'b1, {1'b0, 32'd42}, 1'b0, "mul6x7");

    // Simultaneous requests right after reset: port 0 wins the first tie.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    req0 = 1'b1; op0 = 1'b1; a0 = 32'd100; b0 = 32'd7;
    req1 = 1'b1; op1 = 1'b0; a1 = 32'd3;   b1 = -32'sd5;
    serve(0, 1'b1, 32'd100, 32'd7, 2, 1, 1'b0, 1'b1, {1'b0, 32'd14}, 1'b0, "tie_p0");
    serve(1, 1'b0, 32'd3, -32'sd5, 4, 2, 1'b0, 1'b1, {1'b0, 32'hFFFF_FFF1}, 1'b0, "tie_p1");
    tb_last = 1;

    // Both requests held continuously: grants must alternate.
    req0 = 1'b1; op0 = 1'($urandom_range(0, 1)); a0 = $urandom; b0 = $urandom_range(1, 999);
    req1 = 1'b1; op1 = 1'($urandom_range(0, 1)); a1 = $urandom; b1 = $urandom_range(1, 999);
    for (int i = 0; i < 4; i++) begin
      port = (tb_last == 0) ? 1 : 0;
      if (port == 0) serve(0, op0, a0, b0, $urandom_range(1, 6), 2, 1'b0, 1'b0,
                           ref_op(op0, a0, b0), 1'b0, "fair");
      else serve(1, op1, a1, b1, $urandom_range(1, 6), 2, 1'b0, 1'b0,
                 ref_op(op1, a1, b1), 1'b0, "fair");
      tb_last = port;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Divide by zero: exception comes straight from the unit.
    req1 = 1'b1; op1 = 1'b1; a1 = 32'd5; b1 = 32'd0;
    serve(1, 1'b1, 32'd5, 32'd0, 3, 2, 1'b0, 1'b1, {1'b1, 32'd0}, 1'b0, "div0");

    // Randomized single-requester operations.
    for (int i = 0; i < 8; i++) begin
      port = $urandom_range(0, 1);
      op   = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      if ($urandom_range(0, 1) == 1) b = -b;
      if (port == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
      else begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      serve(port, op, a, b, $urandom_range(1, 6), 2, 1'b0, 1'b1, ref_op(op, a, b), 1'b0, "rand");
    end

`ifdef MULTDIV_ARB_TIMEOUT_EN
    // Unit never answers: abort 8 cycles after WAIT entry.
    req1 = 1'b1; op1 = 1'b0; a1 = 32'd9; b1 = 32'd9;
    serve(1, 1'b0, 32'd9, 32'd9, 7, 2, 1'b1, 1'b1, {1'b1, 32'd0}, 1'b1, "timeout");
`endif

    // Reset during WAIT with a hung unit.
    mhang = 1'b1;
    req0 = 1'b1; op0 = 1'b1; a0 = 32'd77; b0 = 32'd11;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!gnt0 && n < 20);
    chk("hang/gnt_dly", 64'(n), 64'd2);
    req0 = 1'b0;
    seen_done = 1'b0;
`ifdef MULTDIV_ARB_TIMEOUT_EN
    repeat (3) begin
`else
    repeat (50) begin
`endif
      @(negedge clock);
      if (done0 || done1) seen_done = 1'b1;
    end
    chk("hang/no_done", seen_done, 1'b0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk_reset_outputs("midwait_reset");
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (done0 || done1) seen_done = 1'b1;
    end
    chk("midwait_reset/no_done", seen_done, 1'b0);
    req0 = 1'b1; op0 = 1'b0; a0 = 32'd2; b0 = 32'd3;
    serve(0, 1'b0, 32'd2, 32'd3, 2, 1, 1'b0, 1'b1, {1'b0, 32'd6}, 1'b0, "after_reset");

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_arbiter.md
# multdiv_arbiter

Shares the single iterative multiply/divide unit between two requesters (port 0: processor execute stage, port 1: auxiliary requester such as a scoring/DSP engine). It accepts requests with a req/gnt handshake, arbitrates them round-robin, and latches operands and operation. It issues a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, waits for `data_resultRDY`, then returns the result and exception to the owning requester with a one-cycle done pulse. Only one operation is in flight at a time.

## Interface
- `TIMEOUT`, default 40: maximum WAIT cycles before abort (only with `MULTDIV_ARB_TIMEOUT_EN`); legal range ≥ 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req0` / `req1`  in  1  request; held high with operands stable until the matching `gnt` pulse.
- `op0` / `op1`  in  1  0 = multiply, 1 = divide (A/B).
- `a0`, `b0` / `a1`, `b1`  in  32  operands, two's complement.
- `gnt0` / `gnt1`  out  1  one-cycle accept pulse.
- `done0` / `done1`  out  1  one-cycle result-valid pulse.
- `result`  out  32  shared result register, valid when any `done` is high; holds until the next DONE.
- `exception`  out  1  shared; the multdiv exception, or 1 on timeout.
- `timeout`  out  1  shared; 1 if the last op aborted.
- `md_operandA`, `md_operandB`  out  32  latched operands to multdiv.
- `md_ctrl_MULT`, `md_ctrl_DIV`  out  1  start pulses to multdiv.
- `md_result`  in  32  result from multdiv.
- `md_exception`, `md_resultRDY`  in  1  exception and ready from multdiv.

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- **IDLE**
  - If neither req is high: stay in IDLE.
  - If exactly one req is high: select it.
  - If both are high: select the port ≠ `last` (round-robin pointer).
  - On selection: latch `owner`, `op`, A and B into internal registers, then go to START.
- **START** (exactly one cycle)
  - `gnt[owner]` = 1.
  - `md_ctrl_MULT` = ~op and `md_ctrl_DIV` = op.
  - Clear the WAIT counter, then go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - `md_resultRDY` is ignored while counter = 0, because multdiv clears on start and RDY may be stale.
  - When RDY is sampled high: capture `result` ← `md_result`, `exception` ← `md_exception`, `timeout` ← 0. Go to DONE.
  - Timeout (with macro only): when counter = TIMEOUT−1 and RDY is low, set `result` ← 0, `exception` ← 1, `timeout` ← 1. Go to DONE.
- **DONE** (exactly one cycle)
  - `done[owner]` = 1.
  - `last` ← owner.
  - Go to IDLE.
- `md_operandA`/`md_operandB` are driven from the latched registers in all states and stay stable throughout an operation.
- Requests arriving while not in IDLE are not sampled; they wait in IDLE. A req still high after its gnt counts as a new request.
- The arbiter does not check or modify arithmetic; the multdiv unit defines the result width and overflow/div-by-zero exception semantics.
- Counter width is clog2(TIMEOUT+1).

## Timing
- Reset (`reset_n` low at an edge, in any state including mid-WAIT): the next state is IDLE.
  - All outputs become 0: `gnt*`, `done*`, `md_ctrl_*`, `result`, `exception`, `timeout`, `md_operand*`.
  - `last` ← 1, so port 0 wins the first tie.
  - A multdiv op in flight is abandoned; the next start pulse clears it.
- Request sampled in IDLE at edge k:
  - `gnt` and start pulse during cycle k+1.
  - WAIT begins at k+2.
- If `md_resultRDY` is first sampled high at edge m (in WAIT, counter ≥ 1): `done`, `result` and `exception` are valid in cycle m+1.
- The arbiter adds 3 cycles (IDLE, START, DONE). Back-to-back ops are separated by at least one IDLE cycle.
- `gnt` and `done` are never high for both ports in the same cycle. At most one of `md_ctrl_MULT`/`md_ctrl_DIV` is high, for exactly one cycle per op.

## Configuration
- `MULTDIV_ARB_TIMEOUT_EN` defined: the WAIT counter and abort path are compiled in, as described above.
- Undefined: the counter and abort path are removed. WAIT waits indefinitely for `md_resultRDY` (still ignoring the first WAIT cycle, which uses a 1-bit flag). `timeout` is tied to 0 and `TIMEOUT` is unused.

## Test plan
- **Single multiply:** after reset, req0=1, op0=0, a0=6, b0=7.
  - Expect `gnt0` one cycle later, a single `md_ctrl_MULT` pulse, then `done0` with result=42, exception=0.
- **Simultaneous requests after reset:** req0 div 100/7 and req1 mult 3×−5.
  - Expect port 0 served first (result=14), then port 1 (result=0xFFFFFFF1).
  - `gnt1` appears only after `done0`.
- **Fairness:** both reqs held continuously for 4 ops.
  - Expect grant order 0, 1, 0, 1, with no overlapping gnt/done between ports.
- **Divide by zero:** req1 div 5/0.
  - Expect `done1` with exception=1 and timeout=0, exception passed through from multdiv.
- **Timeout:** macro defined, TIMEOUT=8, multdiv model never asserts RDY.
  - Expect done 8 cycles after WAIT entry, with timeout=1, exception=1, result=0.
  - With the macro undefined, the arbiter stays in WAIT.
- **Reset mid-WAIT:** assert `reset_n`=0 for one edge during WAIT.
  - Expect all outputs 0 next cycle, no spurious `done`.
  - A following req0 mult 2×3 returns 6.
